// File: rtl/led_blink_core_pkg.sv
// Shared definitions for the LED blink/breathe core:
// mode encodings, ramp direction and a counter width helper.
package led_pkg;

   localparam int MODE_BLINK   = 0;
   localparam int MODE_BREATHE = 1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   // clog2 of n with a floor of one bit, so a divide-by-1 still has a register
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/led_blink_core_tick_prescaler.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags
// the last count of each period as a one-cycle tick.
module tick_prescaler
   import led_pkg::*;
#(
   parameter int TICK_DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CW = cnt_width(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/led_blink_core.sv
// LED driver: square-wave blink or triangle-ramped PWM breathing,
// both paced by a shared prescaler tick.
module led_blink_core
   import led_pkg::*;
#(
   parameter int TICK_DIV = 10,
   parameter int MODE     = 0,
   parameter int PWM_BITS = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic led
);

   // Any unknown mode collapses onto blink
   localparam int MODE_EFF =
      (MODE == MODE_BREATHE) ? MODE_BREATHE : MODE_BLINK;

   logic tick;

   tick_prescaler #(
      .TICK_DIV(TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   generate
      if (MODE_EFF == MODE_BREATHE) begin : g_breathe

         localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

         dir_t                dir_q;
         dir_t                dir_d;
         logic [PWM_BITS-1:0] duty_q;
         logic [PWM_BITS-1:0] duty_d;
         logic [PWM_BITS-1:0] pwm_q;
         logic                led_d;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               dir_q  <= DIR_UP;
               duty_q <= '0;
               pwm_q  <= '0;
               led    <= 1'b0;
            end else begin
               dir_q  <= dir_d;
               duty_q <= duty_d;
               pwm_q  <= pwm_q + PWM_BITS'(1);
               led    <= led_d;
            end
         end

         // At either end of the ramp the tick only turns around
         always_comb begin
            dir_d  = dir_q;
            duty_d = duty_q;
            led_d  = (pwm_q < duty_q);
            if (tick) begin
               unique case (dir_q)
                  DIR_UP: begin
                     if (duty_q == DUTY_MAX) begin
                        dir_d = DIR_DOWN;
                     end else begin
                        duty_d = duty_q + PWM_BITS'(1);
                     end
                  end
                  DIR_DOWN: begin
                     if (duty_q == '0) begin
                        dir_d = DIR_UP;
                     end else begin
                        duty_d = duty_q - PWM_BITS'(1);
                     end
                  end
                  default: begin
                     dir_d = DIR_UP;
                  end
               endcase
            end
         end

      end else begin : g_blink

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               led <= 1'b0;
            end else if (tick) begin
               led <= ~led;
            end
         end

      end
   endgenerate

endmodule

// File: tb/tb_led_blink_core.sv
// Bench for led_blink_core: four configurations checked each cycle
// against arithmetic models of blink and breathe waveforms.
module tb_led_blink_core;

   logic clk;
   logic rst_n;
   logic led_a;
   logic led_b;
   logic led_c;
   logic led_d;

   int total;
   int bad;
   int k;

   led_blink_core #(.TICK_DIV(10), .MODE(0), .PWM_BITS(4)) u_blink (
      .clk(clk), .rst_n(rst_n), .led(led_a)
   );

   led_blink_core #(.TICK_DIV(1), .MODE(0), .PWM_BITS(4)) u_div1 (
      .clk(clk), .rst_n(rst_n), .led(led_b)
   );

   led_blink_core #(.TICK_DIV(4), .MODE(1), .PWM_BITS(2)) u_breathe (
      .clk(clk), .rst_n(rst_n), .led(led_c)
   );

   led_blink_core #(.TICK_DIV(10), .MODE(3), .PWM_BITS(4)) u_inv (
      .clk(clk), .rst_n(rst_n), .led(led_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // k = rising edges since release; led toggles every div edges
   function automatic logic blink_exp(input int edges, input int div);
      return ((edges / div) % 2) == 1;
   endfunction

   // Triangle duty after n ticks: 0,1,2,3,3,2,1,0,0,1,...
   function automatic int duty_of(input int n);
      int m;
      m = n % 8;
      return (m <= 3) ? m : 7 - m;
   endfunction

   // Output after edge k reflects pwm count and duty held before it
   function automatic logic breathe_exp(input int edges);
      int n;
      int p;
      if (edges == 0) return 1'b0;
      n = (edges - 1) / 4;
      p = (edges - 1) % 4;
      return p < duty_of(n);
   endfunction

   task automatic chk(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s k=%0d got=%b exp=%b", tag, k, got, exp);
      end
   endtask

   task automatic chk_all();
      chk("blink", led_a, blink_exp(k, 10));
      chk("div1", led_b, blink_exp(k, 1));
      chk("breathe", led_c, breathe_exp(k));
      chk("bad_mode", led_d, blink_exp(k, 10));
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) k++;
      #1;
      chk_all();
   endtask

   time t_last;
   time t_now;
   int  n_tr;
   logic prev;

   initial begin
      total = 0;
      bad   = 0;
      k     = 0;
      rst_n = 1'b0;

      // Reset hold with clock running
      repeat (2) step();
      #4;
      rst_n = 1'b1;

      // Blink timing until 2000 ns
      n_tr   = 0;
      prev   = led_a;
      t_last = 0;
      while ($time < 2000) begin
         step();
         if (led_a !== prev) begin
            t_now = $time;
            if (n_tr > 0) begin
               total++;
               assert (t_now - t_last == 100) else begin
                  bad++;
                  $error("FAIL interval got=%0t exp=100", t_now - t_last);
               end
            end
            n_tr++;
            t_last = t_now;
            prev   = led_a;
         end
      end
      total++;
      assert (n_tr == k / 10) else begin
         bad++;
         $error("FAIL transitions got=%0d exp=%0d", n_tr, k / 10);
      end

      // Asynchronous reset between edges while the blink LED is high
      chk("pre_rst_high", led_a, 1'b1);
      #3;
      rst_n = 1'b0;
      k = 0;
      #1;
      chk_all();
      repeat (5) step();
      @(negedge clk);
      rst_n = 1'b1;

      // Random run lengths with random mid-run resets
      repeat (10) begin
         repeat ($urandom_range(20, 200)) step();
         #($urandom_range(1, 3));
         rst_n = 1'b0;
         k = 0;
         #1;
         chk_all();
         repeat ($urandom_range(1, 5)) step();
         @(negedge clk);
         #($urandom_range(0, 3));
         rst_n = 1'b1;
      end
      repeat (140) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
